// File: rtl/mole_array_fsm.sv
// Whack-a-mole controller: N_MOLES independent up/down timer channels feeding
// shared saturating hit and miss score counters.
module mole_chan #(
  parameter int TIMER_W = 16,
  parameter int JIT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               tick,
  input  logic [TIMER_W-1:0] on_time,
  input  logic [TIMER_W-1:0] off_time,
  input  logic [JIT_W-1:0]   jitter,
  input  logic               hit,
  output logic               led_on,
  output logic               hit_stb,
  output logic               miss_stb
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD_OFF = 3'd1;
  localparam logic [2:0] OFF      = 3'd2;
  localparam logic [2:0] LOAD_ON  = 3'd3;
  localparam logic [2:0] ON       = 3'd4;

  logic [2:0]         state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W:0]   off_sum;
  logic [TIMER_W-1:0] off_load;
  logic               timer_zero;

  // Extra carry bit catches off_time+jitter overflow so the load clamps instead of wrapping.
  assign off_sum    = {1'b0, off_time} + {{(TIMER_W+1-JIT_W){1'b0}}, jitter};
  assign off_load   = off_sum[TIMER_W] ? '1 : off_sum[TIMER_W-1:0];
  assign timer_zero = (timer == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      led_on   <= 1'b0;
      hit_stb  <= 1'b0;
      miss_stb <= 1'b0;
    end else begin
      hit_stb  <= 1'b0;
      miss_stb <= 1'b0;
      if (!run) begin
        state  <= IDLE;
        led_on <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= LOAD_OFF;
          LOAD_OFF: begin
            timer <= off_load;
            state <= OFF;
          end
          OFF: begin
            if (timer_zero) state <= LOAD_ON;
            else if (tick)  timer <= timer - 1'b1;
          end
          LOAD_ON: begin
            timer  <= on_time;
            state  <= ON;
            led_on <= 1'b1;
          end
          ON: begin
            // A whack in the expiry cycle wins over the miss.
            if (hit) begin
              state   <= LOAD_OFF;
              led_on  <= 1'b0;
              hit_stb <= 1'b1;
            end else if (timer_zero) begin
              state    <= LOAD_OFF;
              led_on   <= 1'b0;
              miss_stb <= 1'b1;
            end else if (tick) begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            led_on <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

module mole_array_fsm #(
  parameter int N_MOLES = 4,
  parameter int TIMER_W = 16,
  parameter int JIT_W   = 4,
  parameter int SCORE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     tick,
  input  logic [TIMER_W-1:0]       on_time,
  input  logic [TIMER_W-1:0]       off_time,
  input  logic [N_MOLES*JIT_W-1:0] jitter,
  input  logic [N_MOLES-1:0]       hit,
  input  logic                     clr_score,
  output logic [N_MOLES-1:0]       led_on,
  output logic [N_MOLES-1:0]       hit_stb,
  output logic [N_MOLES-1:0]       miss_stb,
  output logic [SCORE_W-1:0]       hit_count,
  output logic [SCORE_W-1:0]       miss_count
);
  logic [4:0]         hit_pop, miss_pop;
  logic [SCORE_W+4:0] hit_sum, miss_sum;

  for (genvar g = 0; g < N_MOLES; g++) begin : g_chan
    mole_chan #(.TIMER_W(TIMER_W), .JIT_W(JIT_W)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .tick     (tick),
      .on_time  (on_time),
      .off_time (off_time),
      .jitter   (jitter[g*JIT_W +: JIT_W]),
      .hit      (hit[g]),
      .led_on   (led_on[g]),
      .hit_stb  (hit_stb[g]),
      .miss_stb (miss_stb[g])
    );
  end

  always_comb begin
    hit_pop  = '0;
    miss_pop = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      hit_pop  = hit_pop  + 5'(hit_stb[i]);
      miss_pop = miss_pop + 5'(miss_stb[i]);
    end
    hit_sum  = {5'b0, hit_count}  + {{SCORE_W{1'b0}}, hit_pop};
    miss_sum = {5'b0, miss_count} + {{SCORE_W{1'b0}}, miss_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_score) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      hit_count  <= (|hit_sum[SCORE_W+4:SCORE_W])  ? '1 : hit_sum[SCORE_W-1:0];
      miss_count <= (|miss_sum[SCORE_W+4:SCORE_W]) ? '1 : miss_sum[SCORE_W-1:0];
    end
  end
endmodule

// File: tb/tb_mole_array_fsm.sv
// Scenario bench for mole_array_fsm: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output appears.
module tb_mole_array_fsm;
  localparam int N = 4, TW = 8, JW = 4, SW = 4;

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, tick = 1'b1, clr_score = 1'b0;
  logic [TW-1:0]   on_time = '0, off_time = '0;
  logic [N*JW-1:0] jitter = '0;
  logic [N-1:0]    hit = '0;
  logic [N-1:0]    led_on, hit_stb, miss_stb;
  logic [SW-1:0]   hit_count, miss_count;

  int n_chk = 0, n_pass = 0, cyc = 0;
  bit slow_tick = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  mole_array_fsm #(.N_MOLES(N), .TIMER_W(TW), .JIT_W(JW), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .tick(tick), .on_time(on_time),
    .off_time(off_time), .jitter(jitter), .hit(hit), .clr_score(clr_score),
    .led_on(led_on), .hit_stb(hit_stb), .miss_stb(miss_stb),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs changed 1ns after it.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    tick = slow_tick ? (cyc % 4 == 0) : 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; hit = '0; clr_score = 1'b0; slow_tick = 1'b0; jitter = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic wait_rise(output int d);
    d = 0;
    while (led_on == '0 && d < 400) begin step(); d++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; hit = '1; clr_score = 1'b0;
    repeat (5) exp_q.push_back(0);
    step(); step();
    n_chk++; e = exp_q.pop_front(); if ({28'd0, led_on} !== e) $display("FAIL rst_led got %h want %h", led_on, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, hit_stb} !== e) $display("FAIL rst_hit_stb got %h want %h", hit_stb, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_stb} !== e) $display("FAIL rst_miss_stb got %h want %h", miss_stb, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, hit_count} !== e) $display("FAIL rst_hit_cnt got %0d want %0d", hit_count, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_count} !== e) $display("FAIL rst_miss_cnt got %0d want %0d", miss_count, e); else n_pass++;
    hit = '0; run = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_run_miss();
    int d, h, g;
    do_reset(); off_time = 3; on_time = 2;
    exp_q.push_back(6); exp_q.push_back(32'hF); exp_q.push_back(3); exp_q.push_back(32'hF);
    exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(6);
    run = 1'b1; step();  // this edge samples run: IDLE -> LOAD_OFF
    wait_rise(d);
    n_chk++; e = exp_q.pop_front(); if (d !== e) $display("FAIL rise_delay got %0d want %0d", d, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, led_on} !== e) $display("FAIL rise_led got %h want %h", led_on, e); else n_pass++;
    h = 0;
    while (led_on == 4'hF && h < 50) begin step(); h++; end
    n_chk++; e = exp_q.pop_front(); if (h !== e) $display("FAIL on_len got %0d want %0d", h, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_stb} !== e) $display("FAIL miss_vec got %h want %h", miss_stb, e); else n_pass++;
    step();
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_stb} !== e) $display("FAIL miss_once got %h want %h", miss_stb, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_count} !== e) $display("FAIL miss_cnt4 got %0d want %0d", miss_count, e); else n_pass++;
    g = 2;
    while (led_on == '0 && g < 60) begin step(); if (led_on == '0) g++; end
    n_chk++; e = exp_q.pop_front(); if (g !== e) $display("FAIL off_gap got %0d want %0d", g, e); else n_pass++;
  endtask

  task automatic test_hit();
    int d;
    do_reset(); off_time = 3; on_time = 5;
    exp_q.push_back(0); exp_q.push_back(32'hF); exp_q.push_back(32'h5); exp_q.push_back(32'hA);
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(32'hA); exp_q.push_back(2); exp_q.push_back(2);
    run = 1'b1; step(); step(); step();
    hit = 4'b0010; step(); hit = '0;  // ch1 is in OFF here
    n_chk++; e = exp_q.pop_front(); if ({28'd0, hit_stb} !== e) $display("FAIL hit_off_ign got %h want %h", hit_stb, e); else n_pass++;
    wait_rise(d);
    n_chk++; e = exp_q.pop_front(); if ({28'd0, led_on} !== e) $display("FAIL hit_rise got %h want %h", led_on, e); else n_pass++;
    hit = 4'b0101; step(); hit = '0;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, hit_stb} !== e) $display("FAIL hit_stb got %h want %h", hit_stb, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, led_on} !== e) $display("FAIL hit_led got %h want %h", led_on, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_stb} !== e) $display("FAIL hit_no_miss got %h want %h", miss_stb, e); else n_pass++;
    step();
    n_chk++; e = exp_q.pop_front(); if ({28'd0, hit_count} !== e) $display("FAIL hit_cnt got %0d want %0d", hit_count, e); else n_pass++;
    d = 0;
    while (miss_stb == '0 && d < 50) begin step(); d++; end
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_stb} !== e) $display("FAIL hit_rest_miss got %h want %h", miss_stb, e); else n_pass++;
    step();
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_count} !== e) $display("FAIL hit_miss_cnt got %0d want %0d", miss_count, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, hit_count} !== e) $display("FAIL hit_cnt_hold got %0d want %0d", hit_count, e); else n_pass++;
  endtask

  task automatic test_tie();
    int d;
    do_reset(); off_time = 3; on_time = 2;
    exp_q.push_back(32'h1); exp_q.push_back(32'hE); exp_q.push_back(1); exp_q.push_back(3);
    run = 1'b1; wait_rise(d);
    step(); step();  // timer now 0 in every channel
    hit = 4'b0001; step(); hit = '0;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, hit_stb} !== e) $display("FAIL tie_hit got %h want %h", hit_stb, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_stb} !== e) $display("FAIL tie_miss got %h want %h", miss_stb, e); else n_pass++;
    step();
    n_chk++; e = exp_q.pop_front(); if ({28'd0, hit_count} !== e) $display("FAIL tie_hit_cnt got %0d want %0d", hit_count, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_count} !== e) $display("FAIL tie_miss_cnt got %0d want %0d", miss_count, e); else n_pass++;
  endtask

  task automatic test_jitter_tick();
    int rise[N];
    bit seen[N];
    int k;
    do_reset(); off_time = 3; on_time = 20; jitter = {4'd3, 4'd2, 4'd1, 4'd0};
    for (int i = 0; i < N; i++) begin rise[i] = -1; seen[i] = 1'b0; end
    for (int i = 1; i < N; i++) exp_q.push_back(4 * i);
    slow_tick = 1'b1; run = 1'b1;
    k = 0;
    while (!(seen[0] && seen[1] && seen[2] && seen[3]) && k < 300) begin
      step(); k++;
      for (int i = 0; i < N; i++) if (led_on[i] && !seen[i]) begin seen[i] = 1'b1; rise[i] = cyc; end
    end
    for (int i = 1; i < N; i++) begin
      n_chk++; e = exp_q.pop_front();
      if (rise[i] - rise[0] !== int'(e)) $display("FAIL jit_stagger%0d got %0d want %0d", i, rise[i] - rise[0], e); else n_pass++;
    end
  endtask

  task automatic test_off_sat();
    int d;
    do_reset(); off_time = 8'd255; on_time = 1; jitter = {4'd0, 4'd0, 4'd0, 4'd15};
    exp_q.push_back(258); exp_q.push_back(32'hF);
    run = 1'b1; step();
    wait_rise(d);
    n_chk++; e = exp_q.pop_front(); if (d !== e) $display("FAIL sat_load_delay got %0d want %0d", d, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, led_on} !== e) $display("FAIL sat_load_led got %h want %h", led_on, e); else n_pass++;
  endtask

  task automatic test_sat_clear();
    int d;
    do_reset(); off_time = 0; on_time = 0;
    exp_q.push_back(15); exp_q.push_back(0); exp_q.push_back(0);
    run = 1'b1;
    repeat (40) step();  // about 36 misses at 4 per round
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_count} !== e) $display("FAIL miss_sat got %0d want %0d", miss_count, e); else n_pass++;
    d = 0;
    while (miss_stb == '0 && d < 10) begin step(); d++; end
    clr_score = 1'b1; step(); clr_score = 1'b0;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_count} !== e) $display("FAIL clr_miss got %0d want %0d", miss_count, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, hit_count} !== e) $display("FAIL clr_hit got %0d want %0d", hit_count, e); else n_pass++;
  endtask

  task automatic test_abort();
    int d;
    do_reset(); off_time = 3; on_time = 5;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(6);
    run = 1'b1; wait_rise(d); step();
    run = 1'b0; hit = 4'b1000; step(); hit = '0;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, led_on} !== e) $display("FAIL abort_led got %h want %h", led_on, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, hit_stb} !== e) $display("FAIL abort_hit_stb got %h want %h", hit_stb, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_stb} !== e) $display("FAIL abort_miss_stb got %h want %h", miss_stb, e); else n_pass++;
    repeat (8) step();
    n_chk++; e = exp_q.pop_front(); if ({28'd0, hit_count} !== e) $display("FAIL abort_hit_cnt got %0d want %0d", hit_count, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_count} !== e) $display("FAIL abort_miss_cnt got %0d want %0d", miss_count, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, led_on} !== e) $display("FAIL abort_idle_led got %h want %h", led_on, e); else n_pass++;
    run = 1'b1; step();
    wait_rise(d);
    n_chk++; e = exp_q.pop_front(); if (d !== e) $display("FAIL abort_restart got %0d want %0d", d, e); else n_pass++;
  endtask

  task automatic test_reset_mid_on();
    int d;
    do_reset(); off_time = 3; on_time = 5;
    exp_q.push_back(0); exp_q.push_back(0);
    run = 1'b1; wait_rise(d); step();
    rst_n = 1'b0; step();
    n_chk++; e = exp_q.pop_front(); if ({28'd0, led_on} !== e) $display("FAIL rst_on_led got %h want %h", led_on, e); else n_pass++;
    n_chk++; e = exp_q.pop_front(); if ({28'd0, miss_stb} !== e) $display("FAIL rst_on_miss got %h want %h", miss_stb, e); else n_pass++;
    rst_n = 1'b1; run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_miss();
    test_hit();
    test_tie();
    test_jitter_tick();
    test_off_sat();
    test_sat_clear();
    test_abort();
    test_reset_mid_on();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
